// File: rtl/i2s_rx_param.sv
// rtl/i2s_rx_param.sv - oversampled I2S / left-justified serial audio receiver
// Optional word-length checking (oWordLen, oLenErr) is built only with I2S_RX_LENCHK_EN.
module i2s_rx_param #(
  parameter int DATA_W = 24,
  parameter int MODE   = 0
) (
  input  logic              iSysClk,
  input  logic              iRst_n,
  input  logic              iBCK,
  input  logic              iLRCK,
  input  logic              iDataIn,
  output logic              oStrobeL,
  output logic              oStrobeR,
  output logic [DATA_W-1:0] oDataL,
  output logic [DATA_W-1:0] oDataR
`ifdef I2S_RX_LENCHK_EN
  ,
  output logic [$clog2(DATA_W+2)-1:0] oWordLen,
  output logic                        oLenErr
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  logic bck_s1, bck_s2, bck_prev;
  logic lr_s1, lr_s2;
  logic d_s1, d_s2;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  count;
  logic              armed;
  logic              lr_prev;

  logic              bck_rise;
  logic              lr_chg;
  logic [DATA_W-1:0] ins_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] final_word;
  logic [CNT_W-1:0]  final_len;

  always_ff @(posedge iSysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      bck_s1   <= 1'b0;
      bck_s2   <= 1'b0;
      bck_prev <= 1'b0;
      lr_s1    <= 1'b0;
      lr_s2    <= 1'b0;
      d_s1     <= 1'b0;
      d_s2     <= 1'b0;
    end else begin
      bck_s1   <= iBCK;
      bck_s2   <= bck_s1;
      bck_prev <= bck_s2;
      lr_s1    <= iLRCK;
      lr_s2    <= lr_s1;
      d_s1     <= iDataIn;
      d_s2     <= d_s1;
    end
  end

  // Bits past DATA_W are dropped; the counter keeps counting up to DATA_W+1 to flag truncation.
  always_comb begin
    bck_rise = bck_s2 & ~bck_prev;
    lr_chg   = lr_s2 ^ lr_prev;
    ins_word = shreg;
    if (count < CNT_FULL) begin
      ins_word = shreg | (DATA_W'(d_s2) << (CNT_FULL - CNT_ONE - count));
    end
    cnt_inc = (count == CNT_SAT) ? count : count + CNT_ONE;
    if (MODE == 0) begin
      final_word = ins_word;
      final_len  = cnt_inc;
    end else begin
      final_word = shreg;
      final_len  = count;
    end
  end

  always_ff @(posedge iSysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shreg    <= '0;
      count    <= '0;
      armed    <= 1'b0;
      lr_prev  <= 1'b0;
      oStrobeL <= 1'b0;
      oStrobeR <= 1'b0;
      oDataL   <= '0;
      oDataR   <= '0;
`ifdef I2S_RX_LENCHK_EN
      oWordLen <= '0;
      oLenErr  <= 1'b0;
`endif
    end else begin
      oStrobeL <= 1'b0;
      oStrobeR <= 1'b0;
`ifdef I2S_RX_LENCHK_EN
      oLenErr  <= 1'b0;
`endif
      if (bck_rise) begin
        lr_prev <= lr_s2;
        if (!lr_chg) begin
          shreg <= ins_word;
          count <= cnt_inc;
        end else begin
          if (MODE == 0) begin
            shreg <= '0;
            count <= '0;
          end else begin
            shreg <= {d_s2, {(DATA_W-1){1'b0}}};
            count <= CNT_ONE;
          end
          // The word ending at the first change after reset was partial, so it only arms.
          armed <= 1'b1;
          if (armed) begin
            if (!lr_prev) begin
              oDataL   <= final_word;
              oStrobeL <= 1'b1;
            end else begin
              oDataR   <= final_word;
              oStrobeR <= 1'b1;
            end
`ifdef I2S_RX_LENCHK_EN
            oWordLen <= final_len;
            oLenErr  <= (final_len == '0) || (final_len == CNT_SAT);
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_param.sv
// tb/tb_i2s_rx_param.sv - directed bench for i2s_rx_param in I2S and left-justified modes
module tb_i2s_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bck = 1'b0;
  logic lrck = 1'b0;
  logic din = 1'b0;

  logic        s_l0, s_r0, s_l1, s_r1;
  logic [23:0] d_l0, d_r0, d_l1, d_r1;
`ifdef I2S_RX_LENCHK_EN
  logic [4:0]  wl0, wl1;
  logic        le0, le1;
`endif

  int checks = 0;
  int errors = 0;
  int sl0 = 0, sr0 = 0, sl1 = 0, sr1 = 0, err0 = 0, dual = 0;

  always #2 clk = ~clk;

  i2s_rx_param #(.DATA_W(24), .MODE(0)) dut0 (
    .iSysClk(clk), .iRst_n(rst_n), .iBCK(bck), .iLRCK(lrck), .iDataIn(din),
    .oStrobeL(s_l0), .oStrobeR(s_r0), .oDataL(d_l0), .oDataR(d_r0)
`ifdef I2S_RX_LENCHK_EN
    , .oWordLen(wl0), .oLenErr(le0)
`endif
  );

  i2s_rx_param #(.DATA_W(24), .MODE(1)) dut1 (
    .iSysClk(clk), .iRst_n(rst_n), .iBCK(bck), .iLRCK(lrck), .iDataIn(din),
    .oStrobeL(s_l1), .oStrobeR(s_r1), .oDataL(d_l1), .oDataR(d_r1)
`ifdef I2S_RX_LENCHK_EN
    , .oWordLen(wl1), .oLenErr(le1)
`endif
  );

  always @(negedge clk) begin
    if (s_l0) sl0++;
    if (s_r0) sr0++;
    if (s_l1) sl1++;
    if (s_r1) sr1++;
    if ((s_l0 && s_r0) || (s_l1 && s_r1)) dual++;
`ifdef I2S_RX_LENCHK_EN
    if (le0) err0++;
`endif
  end

  typedef struct {
    logic        side;
    logic [31:0] w;
    int          n;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    lrck = lr;
    din  = d;
    #10 bck = 1'b1;
    #10 bck = 1'b0;
  endtask

  // I2S: LRCK flips on the LSB, one BCK ahead of the next MSB
  task automatic send_i2s(input logic side, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit((i == n - 1) ? ~side : side, w[31-i]);
    #16;
  endtask

  task automatic send_lj(input logic side, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(side, w[31-i]);
    #16;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lrck  = 1'b0;
    din   = 1'b0;
    bck   = 1'b0;
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int b_l, b_r, b_e, lat;

  initial begin
    tbl[0] = '{1'b1, {24'hABCDEF, 8'h00},  24, 24'hABCDEF};
    tbl[1] = '{1'b0, {16'h8001, 16'h0000}, 16, 24'h800100};
    tbl[2] = '{1'b1, {20'hF00D5, 12'h000}, 20, 24'hF00D50};
    tbl[3] = '{1'b0, {8'hA5, 24'h000000},   8, 24'hA50000};
    tbl[4] = '{1'b1, 32'h0000_0000,         1, 24'h000000};
    tbl[5] = '{1'b0, {24'h000001, 8'h00},  24, 24'h000001};
    tbl[6] = '{1'b1, {16'hFFFE, 16'h0000}, 16, 24'hFFFE00};
    tbl[7] = '{1'b0, {24'h5A5A5A, 8'hFF},  32, 24'h5A5A5A};

    #9;
    chk("rst_data_l", {8'h0, d_l0}, 32'h0);
    chk("rst_data_r", {8'h0, d_r0}, 32'h0);
    chk("rst_strobes", {28'h0, s_l0, s_r0, s_l1, s_r1}, 32'h0);
    do_reset();

    // I2S basic: first word only arms
    b_l = sl0; b_r = sr0;
    send_i2s(1'b0, {16'h1111, 16'h0}, 16);
    chk("arm_suppress_cnt", sl0 - b_l, 0);
    chk("arm_suppress_data", {8'h0, d_l0}, 32'h0);
    send_i2s(1'b1, {16'h2F6D, 16'h0}, 16);
    send_i2s(1'b0, {16'hA72D, 16'h0}, 16);
    chk("i2s_data_l", {8'h0, d_l0}, 32'h00A72D00);
    chk("i2s_data_r", {8'h0, d_r0}, 32'h002F6D00);
    chk("i2s_cnt_l", sl0 - b_l, 1);
    chk("i2s_cnt_r", sr0 - b_r, 1);

    // edge patterns 0x0001 / 0xFFFE
    do_reset();
    b_e = err0;
    send_i2s(1'b0, {16'h0F0F, 16'h0}, 16);
    send_i2s(1'b1, {16'h0001, 16'h0}, 16);
    chk("pat_data_r", {8'h0, d_r0}, 32'h00000100);
`ifdef I2S_RX_LENCHK_EN
    chk("pat_wordlen_r", {27'h0, wl0}, 32'd16);
`endif
    send_i2s(1'b0, {16'hFFFE, 16'h0}, 16);
    chk("pat_data_l", {8'h0, d_l0}, 32'h00FFFE00);
`ifdef I2S_RX_LENCHK_EN
    chk("pat_wordlen_l", {27'h0, wl0}, 32'd16);
    chk("pat_lenerr", err0 - b_e, 0);
`endif

    // left-justified with latency measurement
    do_reset();
    b_l = sl1; b_r = sr1;
    send_lj(1'b0, 32'h5A00_0000, 8);
    send_lj(1'b1, {24'hABCDEF, 8'h0}, 24);
    send_lj(1'b0, {24'h123456, 8'h0}, 24);
    lrck = 1'b1;
    din  = 1'b0;
    #10 bck = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (s_l1 && lat < 0) lat = k;
    end
    @(posedge clk);
    #1 bck = 1'b0;
    #16;
    chk("lj_latency", {31'h0, (lat >= 3 && lat <= 5)}, 32'd1);
    chk("lj_data_l", {8'h0, d_l1}, 32'h00123456);
    chk("lj_data_r", {8'h0, d_r1}, 32'h00ABCDEF);
    chk("lj_cnt_l", sl1 - b_l, 1);
    chk("lj_cnt_r", sr1 - b_r, 1);

    // overlong slot: 26 bits into 24
    do_reset();
    send_i2s(1'b0, {16'h0F0F, 16'h0}, 16);
    b_e = err0;
    send_i2s(1'b1, {24'hC3A5F0, 2'b11, 6'b0}, 26);
    chk("trunc_data_r", {8'h0, d_r0}, 32'h00C3A5F0);
`ifdef I2S_RX_LENCHK_EN
    chk("trunc_wordlen", {27'h0, wl0}, 32'd25);
    chk("trunc_lenerr", err0 - b_e, 1);
`endif

    // reset mid-word
    do_reset();
    send_i2s(1'b0, {16'h0F0F, 16'h0}, 16);
    send_i2s(1'b1, {16'h2F6D, 16'h0}, 16);
    chk("mid_pre_data_r", {8'h0, d_r0}, 32'h002F6D00);
    for (int i = 0; i < 8; i++) send_bit(1'b0, i[0]);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data_r", {8'h0, d_r0}, 32'h0);
    chk("mid_rst_data_l", {8'h0, d_l0}, 32'h0);
    chk("mid_rst_data_lj", {8'h0, d_l1 | d_r1}, 32'h0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_l = sl0; b_r = sr0;
    send_i2s(1'b0, {16'h5555, 16'h0}, 16);
    send_i2s(1'b1, {16'h1234, 16'h0}, 16);
    chk("mid_post_cnt_l", sl0 - b_l, 0);
    chk("mid_post_cnt_r", sr0 - b_r, 1);
    chk("mid_post_data_r", {8'h0, d_r0}, 32'h00123400);
    chk("mid_post_data_l", {8'h0, d_l0}, 32'h0);

    // four continuous frames at 5x oversampling
    do_reset();
    send_i2s(1'b0, {16'h0F0F, 16'h0}, 16);
    for (int v = 0; v < 8; v++) begin
      b_l = sl0; b_r = sr0;
      send_i2s(tbl[v].side, tbl[v].w, tbl[v].n);
      if (tbl[v].side) begin
        chk($sformatf("tbl%0d_data_r", v), {8'h0, d_r0}, {8'h0, tbl[v].exp});
        chk($sformatf("tbl%0d_cnt", v), (sr0 - b_r) * 16 + (sl0 - b_l), 16);
      end else begin
        chk($sformatf("tbl%0d_data_l", v), {8'h0, d_l0}, {8'h0, tbl[v].exp});
        chk($sformatf("tbl%0d_cnt", v), (sl0 - b_l) * 16 + (sr0 - b_r), 16);
      end
    end

    chk("no_dual_strobe", dual, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
